// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter slice: operand/opcode widths,
// the ALU request bundle, RV32I funct3 encodings and the result-slot states.
package alu_arbiter_pkg;

    localparam int NB_WORD   = 32;
    localparam int NB_FUNCT3 = 3;

    typedef enum logic [NB_FUNCT3-1:0] {
        F3_ADD_SUB = 3'b000,
        F3_SLL     = 3'b001,
        F3_SLT     = 3'b010,
        F3_SLTU    = 3'b011,
        F3_XOR     = 3'b100,
        F3_SRL_SRA = 3'b101,
        F3_OR      = 3'b110,
        F3_AND     = 3'b111
    } funct3_e;

    // One ALU operation as presented by a requester.
    typedef struct packed {
        logic [NB_WORD-1:0]   rs1;
        logic [NB_WORD-1:0]   rs2;
        logic [NB_FUNCT3-1:0] funct3;
        logic                 arith_logic;
    } alu_req_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Requester ID width: clog2 of the requester count, never below one bit.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester and response bus of the ALU arbiter. The master side is the set of
// requesters plus the result consumer; the slave side is the arbiter itself.
interface alu_arbiter_if #(
    parameter int N_REQ = 2
);
    import alu_arbiter_pkg::*;

    localparam int NB_ID = id_width(N_REQ);

    logic [N_REQ-1:0]           i_req_valid;
    logic [N_REQ-1:0]           o_req_ready;
    logic [N_REQ*NB_WORD-1:0]   i_req_rs1;
    logic [N_REQ*NB_WORD-1:0]   i_req_rs2;
    logic [N_REQ*NB_FUNCT3-1:0] i_req_op;
    logic [N_REQ-1:0]           i_req_arith;
    logic                       o_rsp_valid;
    logic                       i_rsp_ready;
    logic [NB_ID-1:0]           o_rsp_id;
    logic [NB_WORD-1:0]         o_rsp_result;

    modport master (
        output i_req_valid, i_req_rs1, i_req_rs2, i_req_op, i_req_arith, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_result
    );

    modport slave (
        input  i_req_valid, i_req_rs1, i_req_rs2, i_req_op, i_req_arith, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_result
    );

endinterface

// File: rtl/alu_arbiter_alu.sv
// RV32I integer ALU: add/sub, shifts, set-less-than and bitwise logic.
// Shift amount is rs2[4:0]; arithmetic wraps, no flags.
module alu
    import alu_arbiter_pkg::*;
(
    input  alu_req_t           i_req,
    output logic [NB_WORD-1:0] o_result
);

    logic [4:0]                shamt;
    logic signed [NB_WORD-1:0] sra_res;
    logic                      slt_res;
    logic                      sltu_res;

    // Signed operations kept in their own expressions so the signedness of the
    // surrounding mux cannot turn SRA into a logical shift.
    assign shamt    = i_req.rs2[4:0];
    assign sra_res  = $signed(i_req.rs1) >>> shamt;
    assign slt_res  = $signed(i_req.rs1) < $signed(i_req.rs2);
    assign sltu_res = i_req.rs1 < i_req.rs2;

    // Operation select on funct3, arith_logic picks SUB / SRA.
    always_comb begin
        o_result = '0;
        case (funct3_e'(i_req.funct3))
            F3_ADD_SUB: o_result = i_req.arith_logic ? (i_req.rs1 - i_req.rs2)
                                                     : (i_req.rs1 + i_req.rs2);
            F3_SLL:     o_result = i_req.rs1 << shamt;
            F3_SLT:     o_result = {{(NB_WORD-1){1'b0}}, slt_res};
            F3_SLTU:    o_result = {{(NB_WORD-1){1'b0}}, sltu_res};
            F3_XOR:     o_result = i_req.rs1 ^ i_req.rs2;
            F3_SRL_SRA: o_result = i_req.arith_logic ? $unsigned(sra_res)
                                                     : (i_req.rs1 >> shamt);
            F3_OR:      o_result = i_req.rs1 | i_req.rs2;
            F3_AND:     o_result = i_req.rs1 & i_req.rs2;
            default:    o_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_rr.sv
// Combinational round-robin picker: the first asserted request found when
// scanning from i_ptr upwards, wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int NB_ID = 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [NB_ID-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [NB_ID-1:0] o_grant_idx,
    output logic             o_any
);

    // Scan from farthest to nearest offset so the one nearest i_ptr wins.
    always_comb begin
        o_grant_idx = '0;
        o_any       = 1'b0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (i_req[NB_ID'((int'(i_ptr) + off) % N_REQ)]) begin
                o_grant_idx = NB_ID'((int'(i_ptr) + off) % N_REQ);
                o_any       = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
        assign o_grant[gi] = o_any && (o_grant_idx == NB_ID'(gi));
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters. One operation is granted per cycle
// in round-robin order; its result lands in a one-entry registered slot that
// drains under valid/ready backpressure and can refill on the same edge.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    alu_arbiter_if.slave bus
);

    localparam int NB_ID = id_width(N_REQ);

    alu_req_t           req_arr [N_REQ];
    alu_req_t           alu_in;
    logic [NB_WORD-1:0] alu_result;
    logic [N_REQ-1:0]   grant;
    logic [NB_ID-1:0]   grant_idx;
    logic               grant_any;
    logic               can_accept;
    logic               accept;

    slot_state_e        state_q, state_d;
    logic [NB_ID-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NB_ID-1:0]   rsp_id_q, rsp_id_d;
    logic [NB_WORD-1:0] rsp_result_q, rsp_result_d;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign req_arr[gi] = '{
            rs1:         bus.i_req_rs1[gi*NB_WORD +: NB_WORD],
            rs2:         bus.i_req_rs2[gi*NB_WORD +: NB_WORD],
            funct3:      bus.i_req_op[gi*NB_FUNCT3 +: NB_FUNCT3],
            arith_logic: bus.i_req_arith[gi]
        };
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .NB_ID (NB_ID)
    ) u_rr_arbiter (
        .i_req       (bus.i_req_valid),
        .i_ptr       (rr_ptr_q),
        .o_grant     (grant),
        .o_grant_idx (grant_idx),
        .o_any       (grant_any)
    );

    assign alu_in = req_arr[grant_idx];

    alu u_alu (
        .i_req    (alu_in),
        .o_result (alu_result)
    );

    // The slot can take a new result when empty or when it drains this cycle;
    // nothing is offered while reset is held.
    assign can_accept      = (state_q == SLOT_EMPTY) || bus.i_rsp_ready;
    assign accept          = i_rst_n && can_accept && grant_any;
    assign bus.o_req_ready = (i_rst_n && can_accept) ? grant : '0;

    assign bus.o_rsp_valid  = (state_q == SLOT_FULL);
    assign bus.o_rsp_id     = rsp_id_q;
    assign bus.o_rsp_result = rsp_result_q;

    // Slot FSM next state, result capture and round-robin pointer advance.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        case (state_q)
            SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
            SLOT_FULL:  if (bus.i_rsp_ready && !accept) state_d = SLOT_EMPTY;
            default:    state_d = SLOT_EMPTY;
        endcase
        if (accept) begin
            rsp_id_d     = grant_idx;
            rsp_result_d = alu_result;
            rr_ptr_d     = (grant_idx == NB_ID'(N_REQ - 1)) ? '0 : grant_idx + NB_ID'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q      <= SLOT_EMPTY;
            rr_ptr_q     <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

endmodule
